// File: rtl/dmem_wait_responder.sv
// Data-bus responder: byte-masked word RAM with programmable wait states.
// Define DMEM_ACCESS_COUNT_EN to add saturating load/store access counters.
module dmem_wait_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        wr,
  input  logic [3:0]  mask,
  input  logic [31:0] addr,
  input  logic [31:0] data_wr,
  output logic [31:0] data_rd,
  output logic        ready,
  output logic        busy,
  output logic        err
`ifdef DMEM_ACCESS_COUNT_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  localparam int AW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_L =
    30'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] WAIT_L =
    CNT_W'(WAIT_CYCLES);
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic        q_wr;
  logic [3:0]  q_mask;
  logic [29:0] q_idx;
  logic [31:0] q_data;

  logic [31:0] mem [DEPTH_WORDS];

  logic        go_done;
  logic        r_wr;
  logic [3:0]  r_mask;
  logic [29:0] r_idx;
  logic [31:0] r_data;
  logic        r_hit;
  logic [AW-1:0] r_row;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr[1:0];

  // Select the request that completes on this edge: live inputs
  // when there are no wait states, otherwise the captured copy.
  always_comb begin
    go_done = 1'b0;
    r_wr    = q_wr;
    r_mask  = q_mask;
    r_idx   = q_idx;
    r_data  = q_data;
    unique case (state)
      S_IDLE: begin
        r_wr    = wr;
        r_mask  = mask;
        r_idx   = addr[31:2];
        r_data  = data_wr;
        go_done = cs && NO_WAIT;
      end
      S_WAIT: begin
        go_done = (cnt <= CNT_W'(1));
      end
      default: begin
        go_done = 1'b0;
      end
    endcase
  end

  assign r_hit = (r_idx < DEPTH_L);
  assign r_row = r_idx[AW-1:0];

  // Byte-lane RAM write on the edge entering DONE; never in reset.
  always_ff @(posedge clk) begin
    if (go_done && r_wr && r_hit && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (r_mask[i]) begin
          mem[r_row][8*i +: 8] <= r_data[8*i +: 8];
        end
      end
    end
  end

  // Request FSM with registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      q_wr    <= 1'b0;
      q_mask  <= '0;
      q_idx   <= '0;
      q_data  <= '0;
      data_rd <= '0;
      ready   <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
`ifdef DMEM_ACCESS_COUNT_EN
      rd_count <= '0;
      wr_count <= '0;
`endif
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      if (go_done) begin
        ready <= 1'b1;
        err   <= !r_hit;
        if (!r_wr) begin
          data_rd <= r_hit ? mem[r_row] : '0;
        end
`ifdef DMEM_ACCESS_COUNT_EN
        if (r_wr) begin
          if (wr_count != 16'hFFFF) begin
            wr_count <= wr_count + 16'd1;
          end
        end else begin
          if (rd_count != 16'hFFFF) begin
            rd_count <= rd_count + 16'd1;
          end
        end
`endif
      end
      unique case (state)
        S_IDLE: begin
          if (cs) begin
            q_wr   <= wr;
            q_mask <= mask;
            q_idx  <= addr[31:2];
            q_data <= data_wr;
            cnt    <= WAIT_L;
            busy   <= 1'b1;
            if (NO_WAIT) begin
              state <= S_DONE;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (go_done) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Scoreboard bench for dmem_wait_responder (2-wait and 0-wait instances).
// Counter checks are compiled in when DMEM_ACCESS_COUNT_EN is defined.
module tb_dmem_wait_responder;

  localparam int WC    = 2;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cs, wr;
  logic [3:0]  mask;
  logic [31:0] addr, data_wr, data_rd;
  logic        ready, busy, err;
  logic        cs0, wr0;
  logic [3:0]  mask0;
  logic [31:0] addr0, data_wr0, data_rd0;
  logic        ready0, busy0, err0;
`ifdef DMEM_ACCESS_COUNT_EN
  logic [15:0] rd_count, wr_count;
  logic [15:0] rd_count0, wr_count0;
`endif

  dmem_wait_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(WC),
    .CNT_W(4)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .cs(cs),
    .wr(wr),
    .mask(mask),
    .addr(addr),
    .data_wr(data_wr),
    .data_rd(data_rd),
    .ready(ready),
    .busy(busy),
    .err(err)
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    .rd_count(rd_count),
    .wr_count(wr_count)
`endif
  );

  dmem_wait_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(0),
    .CNT_W(4)
  ) u_dut0 (
    .clk(clk),
    .rst(rst),
    .cs(cs0),
    .wr(wr0),
    .mask(mask0),
    .addr(addr0),
    .data_wr(data_wr0),
    .data_rd(data_rd0),
    .ready(ready0),
    .busy(busy0),
    .err(err0)
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    .rd_count(rd_count0),
    .wr_count(wr_count0)
`endif
  );

  typedef struct packed {
    logic [31:0] rd;
    logic        e;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mdl [longint];
  logic [31:0] last_rd [2];
  int checks = 0;
  int errors = 0;

  task automatic predict(input int sel, input logic w,
                         input logic [3:0] m,
                         input logic [31:0] a,
                         input logic [31:0] d);
    longint      key;
    logic [31:0] old;
    logic [29:0] idx;
    exp_t        ex;
    idx  = a[31:2];
    key  = longint'(sel) * 64'h4000_0000 + longint'(idx);
    ex.e = (idx >= 30'(DEPTH));
    if (!w) begin
      if (ex.e) ex.rd = '0;
      else if (mdl.exists(key)) ex.rd = mdl[key];
      else ex.rd = 'x;
      last_rd[sel] = ex.rd;
    end else begin
      if (!ex.e) begin
        old = mdl.exists(key) ? mdl[key] : 'x;
        for (int i = 0; i < 4; i++)
          if (m[i]) old[8*i +: 8] = d[8*i +: 8];
        mdl[key] = old;
      end
      ex.rd = last_rd[sel];
    end
    exp_q.push_back(ex);
  endtask

  task automatic txn(input int sel, input logic w,
                     input logic [3:0] m,
                     input logic [31:0] a,
                     input logic [31:0] d,
                     output int lat,
                     output logic [31:0] rd,
                     output logic e,
                     output logic b1);
    logic rdy;
    @(negedge clk);
    if (sel == 0) begin
      cs0 = 1'b1; wr0 = w; mask0 = m;
      addr0 = a; data_wr0 = d;
    end else begin
      cs = 1'b1; wr = w; mask = m;
      addr = a; data_wr = d;
    end
    predict(sel, w, m, a, d);
    @(posedge clk); #1;
    lat = 1;
    b1  = (sel == 0) ? busy0 : busy;
    rdy = (sel == 0) ? ready0 : ready;
    while (!rdy && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      rdy = (sel == 0) ? ready0 : ready;
    end
    if (!rdy) lat = 0;
    rd = (sel == 0) ? data_rd0 : data_rd;
    e  = (sel == 0) ? err0 : err;
    cs0 = 1'b0;
    cs  = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cs = 0; wr = 0; mask = 0; addr = 0; data_wr = 0;
    cs0 = 0; wr0 = 0; mask0 = 0; addr0 = 0; data_wr0 = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({data_rd, ready, busy, err} !== 35'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h %b%b%b, expected 0 000",
               data_rd, ready, busy, err);
    end
    checks++;
    if ({data_rd0, ready0, busy0, err0} !== 35'h0) begin
      errors++;
      $display("FAIL reset_outputs0: got %h %b%b%b, expected 0 000",
               data_rd0, ready0, busy0, err0);
    end
    @(negedge clk);
    rst = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
  endtask

  task automatic test_store_load();
    int lat;
    logic [31:0] rd;
    logic e, b1;
    exp_t ex;
    logic        tw [2] = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      txn(1, tw[k], 4'hF, 32'h10, 32'hDEADBEEF, lat, rd, e, b1);
      ex = exp_q.pop_front();
      checks++;
      if (lat != WC + 1) begin
        errors++;
        $display("FAIL sl_latency[%0d]: got %0d edges, expected %0d",
                 k, lat, WC + 1);
      end
      checks++;
      if ({rd, e} !== {ex.rd, ex.e}) begin
        errors++;
        $display("FAIL sl_resp[%0d]: got %h err=%b, expected %h err=%b",
                 k, rd, e, ex.rd, ex.e);
      end
      checks++;
      if (b1 !== 1'b1) begin
        errors++;
        $display("FAIL sl_busy[%0d]: got %b, expected 1", k, b1);
      end
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sl_data: got %h, expected DEADBEEF", rd);
    end
  endtask

  task automatic test_byte_mask();
    int lat;
    logic [31:0] rd;
    logic e, b1;
    exp_t ex;
    logic        tw [3] = '{1'b1, 1'b1, 1'b0};
    logic [3:0]  tm [3] = '{4'hF, 4'h5, 4'hF};
    logic [31:0] td [3] = '{32'h11223344, 32'hAABBCCDD, 32'h0};
    for (int k = 0; k < 3; k++) begin
      txn(1, tw[k], tm[k], 32'h20, td[k], lat, rd, e, b1);
      ex = exp_q.pop_front();
      checks++;
      if ({rd, e} !== {ex.rd, ex.e} || lat != WC + 1) begin
        errors++;
        $display("FAIL mask_resp[%0d]: got %h err=%b lat=%0d, expected %h err=%b lat=%0d",
                 k, rd, e, lat, ex.rd, ex.e, WC + 1);
      end
    end
    checks++;
    if (rd !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL mask_data: got %h, expected 11BB33DD", rd);
    end
  endtask

  task automatic test_out_of_range();
    int lat;
    logic [31:0] rd;
    logic e, b1;
    exp_t ex;
    logic        tw [7] = '{1, 0, 1, 0, 1, 0, 0};
    logic [31:0] ta [7] = '{32'h0, 32'h1000, 32'h1000, 32'h0,
                            32'hFFC, 32'hFFC, 32'hFFFFFFFC};
    logic [31:0] td [7] = '{32'h55AA55AA, 32'h0, 32'hFFFFFFFF, 32'h0,
                            32'h0BADCAFE, 32'h0, 32'h0};
    logic        te [7] = '{0, 1, 1, 0, 0, 0, 1};
    for (int k = 0; k < 7; k++) begin
      txn(1, tw[k], 4'hF, ta[k], td[k], lat, rd, e, b1);
      ex = exp_q.pop_front();
      checks++;
      if ({rd, e} !== {ex.rd, te[k]} || lat != WC + 1) begin
        errors++;
        $display("FAIL oor_resp[%0d]: got %h err=%b lat=%0d, expected %h err=%b lat=%0d",
                 k, rd, e, lat, ex.rd, te[k], WC + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, n;
    logic [31:0] rd;
    logic e, b1;
    exp_t ex;
    logic [31:0] tv [4] = '{32'hA0A0_0001, 32'hB1B1_0002,
                            32'hC2C2_0003, 32'hD3D3_0004};
    for (int k = 0; k < 4; k++) begin
      txn(0, 1'b1, 4'hF, 32'(4 * k), tv[k], lat, rd, e, b1);
      ex = exp_q.pop_front();
      checks++;
      if (lat != 1 || e !== 1'b0) begin
        errors++;
        $display("FAIL b2b_preload[%0d]: got lat=%0d err=%b, expected lat=1 err=0",
                 k, lat, e);
      end
    end
    @(negedge clk);
    cs0 = 1'b1; wr0 = 1'b0; mask0 = 4'hF;
    addr0 = 32'h0; data_wr0 = '0;
    predict(0, 1'b0, 4'hF, 32'h0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!ready0 && n < 20);
      ex = exp_q.pop_front();
      checks++;
      if (n != ((k == 0) ? 1 : 2)) begin
        errors++;
        $display("FAIL b2b_spacing[%0d]: got %0d edges, expected %0d",
                 k, n, (k == 0) ? 1 : 2);
      end
      checks++;
      if ({data_rd0, err0} !== {ex.rd, ex.e}) begin
        errors++;
        $display("FAIL b2b_data[%0d]: got %h err=%b, expected %h err=%b",
                 k, data_rd0, err0, ex.rd, ex.e);
      end
      if (k < 3) begin
        addr0 = 32'(4 * (k + 1));
        predict(0, 1'b0, 4'hF, addr0, 32'h0);
      end else begin
        cs0 = 1'b0;
      end
    end
    exp_q.delete();
    @(posedge clk);
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [31:0] rd;
    logic e, b1;
    logic seen;
    exp_t ex;
    txn(1, 1'b1, 4'hF, 32'h40, 32'h01234567, lat, rd, e, b1);
    ex = exp_q.pop_front();
    txn(1, 1'b0, 4'hF, 32'h40, 32'h0, lat, rd, e, b1);
    ex = exp_q.pop_front();
    checks++;
    if (rd !== ex.rd) begin
      errors++;
      $display("FAIL rmid_pre: got %h, expected %h", rd, ex.rd);
    end
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; mask = 4'hF;
    addr = 32'h40; data_wr = 32'hCAFEF00D;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rmid_busy_wait: got %b, expected 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({data_rd, ready, busy, err} !== 35'h0) begin
      errors++;
      $display("FAIL rmid_reset: got %h %b%b%b, expected 0 000",
               data_rd, ready, busy, err);
    end
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ready || busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rmid_no_ready: got activity=%b, expected 0", seen);
    end
    txn(1, 1'b0, 4'hF, 32'h40, 32'h0, lat, rd, e, b1);
    ex = exp_q.pop_front();
    checks++;
    if (rd !== 32'h01234567 || rd !== ex.rd) begin
      errors++;
      $display("FAIL rmid_old_data: got %h, expected 01234567", rd);
    end
  endtask

`ifdef DMEM_ACCESS_COUNT_EN
  task automatic test_counts();
    int lat;
    logic [31:0] rd;
    logic e, b1;
    exp_t ex;
    logic        tw [5] = '{0, 1, 0, 1, 0};
    logic [31:0] ta [5] = '{32'h10, 32'h44, 32'h1000, 32'h1000, 32'h20};
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    checks++;
    if ({rd_count, wr_count} !== 32'h0) begin
      errors++;
      $display("FAIL cnt_reset0: got rd=%0d wr=%0d, expected 0 0",
               rd_count, wr_count);
    end
    for (int k = 0; k < 5; k++) begin
      txn(1, tw[k], 4'hF, ta[k], 32'h5A5A_0000 + 32'(k),
          lat, rd, e, b1);
      ex = exp_q.pop_front();
    end
    checks++;
    if (rd_count !== 16'd3 || wr_count !== 16'd2) begin
      errors++;
      $display("FAIL cnt_value: got rd=%0d wr=%0d, expected 3 2",
               rd_count, wr_count);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({rd_count, wr_count} !== 32'h0) begin
      errors++;
      $display("FAIL cnt_reset: got rd=%0d wr=%0d, expected 0 0",
               rd_count, wr_count);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_store_load();
    test_byte_mask();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
`ifdef DMEM_ACCESS_COUNT_EN
    test_counts();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
